// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit,
// each held CLKS_PER_BIT cycles, with registered true/complement line outputs.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              R,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              Q,
    output logic              q,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               line_q, line_d;
    logic               line_n_q, line_n_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end_s;

    // Next-state logic for the frame sequencer, baud counter and shifter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        bit_end_s = (baud_q == BAUD_LAST);
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d = data_in;
                    baud_d  = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Outputs are derived from the next state so the registered values line
    // up with the cycle the state register enters.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_d[0];
            default:  line_d = 1'b1;
        endcase
        line_n_d = ~line_d;
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q  <= ST_IDLE;
            baud_q   <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            shift_q  <= {DATA_W{1'b0}};
            line_q   <= 1'b1;
            line_n_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            line_n_q <= line_n_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Q     = line_q;
    assign q     = line_n_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Transmit end for the team's registered single-bit capture path: serialises a parallel word into a framed bit stream (start bit, data LSB-first, stop bit) for a downstream flip-flop receiver.
Outputs true and complementary serial lines, both registered, in the same style as the receive-side flop outputs.
Sits between a word producer (valid/ready handshake) and the serial link.

Parameters:
DATA_W, 8, data bits per frame (legal 1..32)
CLKS_PER_BIT, 4, clock cycles each bit is held on the line (legal >= 1)

Ports:
clk  input  1  rising-edge clock; sole clock
R  input  1  synchronous, active-high reset; sampled on posedge clk only
data_in  input  DATA_W  parallel word to send
load  input  1  producer valid; word accepted on posedge where load && ready
ready  output  1  high only in IDLE; producer may present a word
Q  output  1  serial line, idle high
q  output  1  always the complement of Q, registered, never equal to Q
busy  output  1  high from the cycle after acceptance through the last STOP cycle
done  output  1  single-cycle pulse on the last cycle of STOP

Behaviour:
- All outputs registered; all state updates on posedge clk.
- Reset (R=1 at posedge): on the next cycle state=IDLE, Q=1, q=0, ready=1, busy=0, done=0; bit and baud counters cleared; latched word discarded. R has priority over load.
- FSM states and transitions:
  - IDLE: Q=1. On load && ready, latch data_in into shift register, go to START.
  - START: Q=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Q=shift[0] for CLKS_PER_BIT cycles per bit; after each bit, shift right and increment the index. After bit DATA_W-1, go to STOP.
  - STOP: Q=1 for CLKS_PER_BIT cycles; done=1 on the final cycle; then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. With CLKS_PER_BIT=1, each bit occupies exactly one cycle.
- Latency: Q falls (start bit) on the first cycle after the accepting edge.
- Frame length: exactly (DATA_W+2)*CLKS_PER_BIT cycles from the first START cycle through the last STOP cycle.
- ready=0 and busy=1 from the cycle after acceptance until done. ready returns to 1 the cycle after done.
- Back-to-back: if load is held high, the next word is accepted on the first IDLE cycle. The line is therefore high for at least 1 IDLE cycle between frames, in addition to the stop bit.
- load while busy is ignored; no queueing.
- data_in changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: frame aborted; Q=1 and IDLE on the next cycle; done is not pulsed for the aborted frame.
- q==~Q holds every cycle, including the reset cycle.

Test Plan:
1. R=1 for 2 cycles with load=1 and data_in=0xFF -> Q=1, q=0, ready=1, busy=0, done=0; no frame starts while R=1.
2. DATA_W=8, CLKS_PER_BIT=4: send 0xA5 -> Q sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit held 4 cycles. done pulses on cycle 40 after the accepting edge; ready=1 on cycle 41.
3. Hold load=1 with words 0x01 then 0x80 -> two frames separated by exactly 1 idle-high cycle after the stop bit. Data bits are 1,0,0,0,0,0,0,0 for the first frame and 0,0,0,0,0,0,0,1 for the second.
4. While the 0x3C frame is in DATA bit 3, pulse load with 0xFF and change data_in -> the 0x3C frame completes unaltered; 0xFF is not sent.
5. Assert R for 1 cycle during bit 5 of a frame -> next cycle Q=1, q=0, ready=1; no done pulse; a new load of 0x55 then sends a correct full frame.
6. CLKS_PER_BIT=1, DATA_W=4: send 0x9 -> Q sequence 0,1,0,0,1,1, one cycle each; done on cycle 6; q equals ~Q on every cycle.
